// File: rtl/jpeg_pkg.sv
// Shared constants and types for the JPEG coefficient streamer.
// Component encodings follow the output beat order Y, Cb, Cr.
package jpeg_pkg;

  localparam int PIXEL_COUNT   = 64;
  localparam int BEATS_PER_BLK = 3 * PIXEL_COUNT;

  localparam logic [1:0] COMP_Y  = 2'd0;
  localparam logic [1:0] COMP_CB = 2'd1;
  localparam logic [1:0] COMP_CR = 2'd2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } stream_state_t;

  // Component that follows c in beat order; Cr wraps back to Y.
  function automatic logic [1:0] next_comp(input logic [1:0] c);
    return (c == COMP_CR) ? COMP_Y : c + 2'd1;
  endfunction

endpackage

// File: rtl/jpeg_coef_bank.sv
// One ping-pong bank: holds a full Y/Cb/Cr coefficient block loaded in parallel.
// Read data is a pure mux on (component, zigzag index).
module jpeg_coef_bank
  import jpeg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PIX_CNT    = 64,
  parameter int IDX_W      = $clog2(PIX_CNT)
) (
  input  logic                          clk,
  input  logic                          i_load,
  input  logic [DATA_WIDTH*PIX_CNT-1:0] i_y,
  input  logic [DATA_WIDTH*PIX_CNT-1:0] i_cb,
  input  logic [DATA_WIDTH*PIX_CNT-1:0] i_cr,
  input  logic [1:0]                    i_comp,
  input  logic [IDX_W-1:0]              i_idx,
  output logic [DATA_WIDTH-1:0]         o_data
);

  logic [DATA_WIDTH*PIX_CNT-1:0] r_y;
  logic [DATA_WIDTH*PIX_CNT-1:0] r_cb;
  logic [DATA_WIDTH*PIX_CNT-1:0] r_cr;

  // Contents need no reset: a bank is only read after its full flag is set by a load.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_y  <= i_y;
      r_cb <= i_cb;
      r_cr <= i_cr;
    end
  end

  always_comb begin
    o_data = '0;
    case (i_comp)
      COMP_Y:  o_data = r_y [int'(i_idx)*DATA_WIDTH +: DATA_WIDTH];
      COMP_CB: o_data = r_cb[int'(i_idx)*DATA_WIDTH +: DATA_WIDTH];
      COMP_CR: o_data = r_cr[int'(i_idx)*DATA_WIDTH +: DATA_WIDTH];
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/jpeg_coef_streamer.sv
// Captures parallel 8x8 Y/Cb/Cr zigzag blocks into a ping-pong buffer and
// streams them one coefficient per beat over a valid/ready interface.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no beat presented; waiting for the read bank to become full
// ST_STREAM | coef_* holds a valid beat; advances on each handshake
module jpeg_coef_streamer
  import jpeg_pkg::*;
#(
  parameter  int DATA_WIDTH   = 32,
  parameter  int DATA_DEPTH   = 8,
  parameter  int BLKCNT_WIDTH = 16,
  localparam int PIX_CNT      = DATA_DEPTH * DATA_DEPTH,
  localparam int IDX_W        = $clog2(PIX_CNT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          blk_valid,
  input  logic [DATA_WIDTH*PIX_CNT-1:0] y_zigzag,
  input  logic [DATA_WIDTH*PIX_CNT-1:0] cb_zigzag,
  input  logic [DATA_WIDTH*PIX_CNT-1:0] cr_zigzag,
  output logic                          blk_ready,
  output logic [DATA_WIDTH-1:0]         coef_data,
  output logic [1:0]                    coef_comp,
  output logic [IDX_W-1:0]              coef_idx,
  output logic                          coef_last,
  output logic                          coef_valid,
  input  logic                          coef_ready,
  output logic [BLKCNT_WIDTH-1:0]       blk_count,
  output logic                          overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_CNT - 1);

  stream_state_t           r_state;
  logic [1:0]              r_full;
  logic                    r_wr_bank;
  logic                    r_rd_bank;
  logic                    r_valid;
  logic                    r_last;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_comp;
  logic [IDX_W-1:0]        r_idx;
  logic [BLKCNT_WIDTH-1:0] r_blk_count;
  logic                    r_overflow;

  logic                    w_blk_ready;
  logic                    w_capture;
  logic                    w_beat;
  logic                    w_rd_bank;
  logic [1:0]              w_rd_comp;
  logic [IDX_W-1:0]        w_rd_idx;
  logic [DATA_WIDTH-1:0]   w_rd_data0;
  logic [DATA_WIDTH-1:0]   w_rd_data1;
  logic [DATA_WIDTH-1:0]   w_rd_data;

  assign w_blk_ready = ~&r_full;
  assign w_capture   = blk_valid & w_blk_ready;
  assign w_beat      = r_valid & coef_ready;

  // Address of the beat to present after the next edge, so the output stays registered.
  always_comb begin
    w_rd_bank = r_rd_bank;
    w_rd_comp = COMP_Y;
    w_rd_idx  = '0;
    if (r_state == ST_STREAM) begin
      if (r_last) begin
        w_rd_bank = ~r_rd_bank;
      end else if (r_idx == LAST_IDX) begin
        w_rd_comp = next_comp(r_comp);
      end else begin
        w_rd_comp = r_comp;
        w_rd_idx  = r_idx + 1'b1;
      end
    end
  end

  assign w_rd_data = w_rd_bank ? w_rd_data1 : w_rd_data0;

  jpeg_coef_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .PIX_CNT   (PIX_CNT),
    .IDX_W     (IDX_W)
  ) u_bank0 (
    .clk   (clk),
    .i_load(w_capture & ~r_wr_bank),
    .i_y   (y_zigzag),
    .i_cb  (cb_zigzag),
    .i_cr  (cr_zigzag),
    .i_comp(w_rd_comp),
    .i_idx (w_rd_idx),
    .o_data(w_rd_data0)
  );

  jpeg_coef_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .PIX_CNT   (PIX_CNT),
    .IDX_W     (IDX_W)
  ) u_bank1 (
    .clk   (clk),
    .i_load(w_capture & r_wr_bank),
    .i_y   (y_zigzag),
    .i_cb  (cb_zigzag),
    .i_cr  (cr_zigzag),
    .i_comp(w_rd_comp),
    .i_idx (w_rd_idx),
    .o_data(w_rd_data1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_full      <= 2'b00;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_data      <= '0;
      r_comp      <= COMP_Y;
      r_idx       <= '0;
      r_blk_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      // The write bank is always free when capturing, so it never aliases the bank being released.
      if (blk_valid) begin
        if (w_blk_ready) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank         <= ~r_wr_bank;
        end else begin
          r_overflow <= 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (r_full[r_rd_bank]) begin
            r_state <= ST_STREAM;
            r_valid <= 1'b1;
            r_comp  <= COMP_Y;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_data  <= w_rd_data;
          end
        end
        ST_STREAM: begin
          if (w_beat) begin
            if (r_last) begin
              r_full[r_rd_bank] <= 1'b0;
              r_rd_bank         <= ~r_rd_bank;
              r_blk_count       <= r_blk_count + 1'b1;
              r_comp            <= COMP_Y;
              r_idx             <= '0;
              r_last            <= 1'b0;
              if (r_full[~r_rd_bank]) begin
                r_data <= w_rd_data;
              end else begin
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
                r_data  <= '0;
              end
            end else begin
              r_comp <= w_rd_comp;
              r_idx  <= w_rd_idx;
              r_data <= w_rd_data;
              r_last <= (w_rd_comp == COMP_CR) && (w_rd_idx == LAST_IDX);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign blk_ready  = w_blk_ready;
  assign coef_data  = r_data;
  assign coef_comp  = r_comp;
  assign coef_idx   = r_idx;
  assign coef_last  = r_last;
  assign coef_valid = r_valid;
  assign blk_count  = r_blk_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_jpeg_coef_streamer.sv
// Randomized bench for jpeg_coef_streamer against a block-queue reference model.
// Model: accepted blocks expand into a queue of expected beats; occupancy counts held blocks.
module tb_jpeg_coef_streamer;
  import jpeg_pkg::*;

  localparam int DW = 32;
  localparam int NP = PIXEL_COUNT;

  typedef struct packed {
    logic          last;
    logic [1:0]    comp;
    logic [5:0]    idx;
    logic [DW-1:0] data;
  } beat_t;

  logic             clk;
  logic             reset;
  logic             blk_valid;
  logic [DW*NP-1:0] y_v, cb_v, cr_v;
  logic             blk_ready;
  logic [DW-1:0]    coef_data;
  logic [1:0]       coef_comp;
  logic [5:0]       coef_idx;
  logic             coef_last;
  logic             coef_valid;
  logic             coef_ready;
  logic [15:0]      blk_count;
  logic             overflow;

  jpeg_coef_streamer dut (
    .clk       (clk),
    .reset     (reset),
    .blk_valid (blk_valid),
    .y_zigzag  (y_v),
    .cb_zigzag (cb_v),
    .cr_zigzag (cr_v),
    .blk_ready (blk_ready),
    .coef_data (coef_data),
    .coef_comp (coef_comp),
    .coef_idx  (coef_idx),
    .coef_last (coef_last),
    .coef_valid(coef_valid),
    .coef_ready(coef_ready),
    .blk_count (blk_count),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  beat_t       exp_q[$];
  int          occ;
  logic [15:0] exp_cnt;
  logic        exp_ovf;
  logic        chk_next_valid;
  logic        exp_next_valid;
  logic        prev_stall;
  logic [41:0] prev_word;
  int          beats;
  int          rdy_mode;

  task automatic model_clear();
    exp_q.delete();
    occ            = 0;
    exp_cnt        = '0;
    exp_ovf        = 1'b0;
    chk_next_valid = 1'b0;
    exp_next_valid = 1'b0;
    prev_stall     = 1'b0;
    prev_word      = '0;
    beats          = 0;
  endtask

  task automatic push_block();
    logic [DW*NP-1:0] v;
    beat_t b;
    for (int c = 0; c < 3; c++) begin
      v = (c == 0) ? y_v : (c == 1) ? cb_v : cr_v;
      for (int i = 0; i < NP; i++) begin
        b.comp = c[1:0];
        b.idx  = i[5:0];
        b.data = v[i*DW +: DW];
        b.last = (c == 2) && (i == NP - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // Monitor: inputs settle at posedge+1, so the negedge view equals what the next edge samples.
  always @(negedge clk) begin : mon
    logic  acc;
    logic  rel;
    beat_t e;
    if (!reset) begin
      rel = 1'b0;
      if (chk_next_valid) begin
        chk("valid_after_last", coef_valid, exp_next_valid);
        chk_next_valid = 1'b0;
      end
      chk("blk_ready", blk_ready, occ < 2);
      chk("blk_count", blk_count, exp_cnt);
      chk("overflow", overflow, exp_ovf);
      if (prev_stall)
        chk("stall_hold", {coef_valid, coef_last, coef_comp, coef_idx, coef_data}, prev_word);
      if (coef_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", coef_valid, 1'b0);
        end else begin
          e = exp_q[0];
          chk("beat", {coef_last, coef_comp, coef_idx, coef_data}, e);
          if (coef_ready) begin
            void'(exp_q.pop_front());
            beats++;
            rel = e.last;
          end
        end
      end
      acc = blk_valid && (occ < 2);
      if (blk_valid && occ >= 2) exp_ovf = 1'b1;
      if (acc) push_block();
      if (rel) begin
        exp_cnt        = exp_cnt + 16'd1;
        chk_next_valid = 1'b1;
        exp_next_valid = (occ == 2);
      end
      occ = occ + int'(acc) - int'(rel);
      prev_stall = coef_valid && !coef_ready;
      prev_word  = {coef_valid, coef_last, coef_comp, coef_idx, coef_data};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       coef_ready = 1'b1;
        1:       coef_ready = 1'b0;
        default: coef_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic fill(input bit pattern);
    for (int i = 0; i < NP; i++) begin
      y_v [i*DW +: DW] = pattern ? DW'(i)         : $urandom;
      cb_v[i*DW +: DW] = pattern ? DW'(32'h100+i) : $urandom;
      cr_v[i*DW +: DW] = pattern ? DW'(32'h200+i) : $urandom;
    end
  endtask

  task automatic send_blk();
    @(posedge clk);
    #1;
    blk_valid = 1'b1;
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_valid", coef_valid, 1'b0);
    chk("rst_data", coef_data, '0);
    chk("rst_comp", coef_comp, '0);
    chk("rst_idx", coef_idx, '0);
    chk("rst_last", coef_last, 1'b0);
    chk("rst_count", blk_count, '0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_ready", blk_ready, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    #1;
    chk_reset_vals();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || coef_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
    chk("drain_idle", coef_valid, 1'b0);
  endtask

  task automatic wait_cr62(input int budget);
    int n;
    n = 0;
    while (!(coef_valid && coef_comp == COMP_CR && coef_idx == 6'd62) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("cr62_reached", n < budget, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    reset      = 1'b1;
    blk_valid  = 1'b0;
    coef_ready = 1'b1;
    rdy_mode   = 0;
    y_v = '0; cb_v = '0; cr_v = '0;
    model_clear();

    // 1: single pattern block, full throughput, latency
    do_reset();
    fill(1'b1);
    send_blk();
    chk("lat_pre", coef_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_first_valid", coef_valid, 1'b1);
    chk("lat_first_data", coef_data, 32'd0);
    wait_drain(400);
    chk("t1_count", blk_count, 16'd1);

    // 2: backpressure
    do_reset();
    rdy_mode = 2;
    fill(1'b0);
    send_blk();
    wait_drain(2000);
    chk("t2_count", blk_count, 16'd1);
    rdy_mode = 0;

    // 3: back-to-back blocks
    do_reset();
    fill(1'b1);
    send_blk();
    @(posedge clk);
    fill(1'b0);
    send_blk();
    chk("t3_ready_low", blk_ready, 1'b0);
    wait_drain(800);
    chk("t3_count", blk_count, 16'd2);

    // 4: overflow with both banks held
    do_reset();
    rdy_mode = 1;
    @(posedge clk);
    fill(1'b0); send_blk();
    fill(1'b0); send_blk();
    fill(1'b0); send_blk();
    chk("t4_ovf", overflow, 1'b1);
    rdy_mode = 0;
    wait_drain(800);
    chk("t4_count", blk_count, 16'd2);

    // 5a: capture coinciding with last-beat release, other bank free
    do_reset();
    fill(1'b1);
    send_blk();
    fill(1'b0);
    wait_cr62(400);
    @(posedge clk);
    #1;
    chk("t5a_last", coef_last, 1'b1);
    blk_valid = 1'b1;
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    wait_drain(800);
    chk("t5a_count", blk_count, 16'd2);
    chk("t5a_ovf", overflow, 1'b0);

    // 5b: same timing but both banks full, so the block is dropped
    do_reset();
    fill(1'b1); send_blk();
    fill(1'b0); send_blk();
    fill(1'b0);
    wait_cr62(400);
    @(posedge clk);
    #1;
    chk("t5b_last", coef_last, 1'b1);
    blk_valid = 1'b1;
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    wait_drain(800);
    chk("t5b_count", blk_count, 16'd2);
    chk("t5b_ovf", overflow, 1'b1);

    // 6: asynchronous reset mid-block
    do_reset();
    fill(1'b0);
    send_blk();
    n = 0;
    while (beats < 70 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t6_reached70", beats >= 70, 1'b1);
    #2;
    do_reset();
    fill(1'b1);
    send_blk();
    wait_drain(400);
    chk("t6_count", blk_count, 16'd1);

    // Random soak: random arrivals and backpressure
    do_reset();
    rdy_mode = 2;
    for (int k = 0; k < 25; k++) begin
      fill(1'b0);
      send_blk();
      repeat ($urandom_range(0, 250)) @(posedge clk);
      #1;
    end
    rdy_mode = 0;
    wait_drain(1000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
